item_pos_gen: RTL and testbench
===============================

// Module: item_pos_gen
// PURPOSE
//  Generates a new food (item) cell for the snake game after each eat event.
//  Sits beside the game core: it consumes the core's body queue, length and new head, and returns item x/y plus a done flag.
//  Candidates come from a free-running LFSR. Out-of-field and body-occupied candidates are rejected and redrawn.
//  The body check is sequential, one segment per clock, to keep the comparator count at one.
// PARAMETERS
//  XSIZE     48        field width in cells; border cells x=0 and x=XSIZE-1 are walls
//  YSIZE     64        field height in cells; border cells y=0 and y=YSIZE-1 are walls
//  MAX_SIZE  20        number of body queue slots; 6 bits per slot
//  SEED      16'hACE1  LFSR reset value; must be nonzero
// PORTS
//  i_Clk     in   1              system clock
//  i_Rst     in   1              asynchronous active-low reset
//  i_Start   in   1              one-cycle request pulse from the core on an eat edge
//  i_Body_x  in   MAX_SIZE*6     body x queue; slot k is bits [k*6+:6]; slot 0 is the newest
//  i_Body_y  in   MAX_SIZE*6     body y queue, same layout as i_Body_x
//  i_Size    in   12             current snake length
//  i_Head_x  in   6              new head x; used only with ITEMGEN_HEAD_EXCL_EN
//  i_Head_y  in   6              new head y; used only with ITEMGEN_HEAD_EXCL_EN
//  o_Item_x  out  6              accepted item x
//  o_Item_y  out  6              accepted item y
//  o_Done    out  1              level: the result is valid
//  o_Busy    out  1              high while in DRAW or CHECK
// BEHAVIOUR
//  Reset values: o_Item_x=0, o_Item_y=0, o_Done=0, o_Busy=0, state=IDLE, idx=0, lfsr=SEED.
//  Reset is asynchronous; asserting it mid-operation aborts the search and restores all reset values.
//  LFSR
//   - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts every clock in every state.
//   - Candidate: cx=lfsr[5:0], cy=lfsr[11:6].
//  States
//   - IDLE: on i_Start=1, latch N=min(i_Size,MAX_SIZE); clear o_Done; go to DRAW; set o_Busy=1.
//   - DRAW: if 1<=cx<=XSIZE-2 and 1<=cy<=YSIZE-2 (and the head-exclusion test passes, if enabled), latch cand=(cx,cy), set idx=0, go to CHECK.
//     Otherwise stay in DRAW and retry with the next LFSR value on the next clock.
//   - CHECK, idx<N: compare cand with body slot idx. On a match, go to DRAW. Otherwise idx=idx+1.
//   - CHECK, idx==N: o_Item=cand, o_Done=1, o_Busy=0, go to IDLE.
//  Timing
//   - Best case: o_Done rises N+2 clocks after the i_Start edge (N=0 gives 2).
//   - Each rejection adds 1 clock (DRAW) or idx+2 clocks (CHECK).
//  Handshake
//   - o_Done stays high and o_Item stays stable until the next accepted i_Start.
//   - i_Start is ignored while o_Busy=1; no queueing.
//   - i_Start in the same cycle as the IDLE return is accepted on the next IDLE cycle only. The core must re-pulse.
//   - The core holds i_Body_* stable while o_Busy=1. Body slots >= N are never compared.
//  Width rules
//   - idx is 5 bits. i_Size >= MAX_SIZE saturates N to MAX_SIZE.
//   - Comparisons are 6-bit unsigned equality.
// CONFIGURATION
//  ITEMGEN_HEAD_EXCL_EN
//   - Defined: DRAW also rejects cand==(i_Head_x,i_Head_y), so the new item never lands on the head.
//   - Undefined: the i_Head_* ports are present but unused. Only the body queue is excluded.
// TESTING
//  T1 reset: hold i_Rst=0 5 clocks -> all outputs 0; LFSR value after release = SEED.
//  T2 i_Size=0, pulse i_Start -> o_Done=1 within 2+rejection clocks; 1<=o_Item_x<=46; 1<=o_Item_y<=62; o_Busy=0 afterwards.
//  T3 i_Size=3, body=(24,32),(24,33),(24,34), 500 start pulses -> o_Item never in the body, never on a wall; o_Done only after >=5 clocks.
//  T4 i_Size=40 -> N saturates at 20; only slots 0..19 are compared; search still terminates.
//  T5 i_Start pulsed while o_Busy=1 -> ignored; one o_Done per accepted start; o_Item stable until the next start.
//  T6 i_Rst asserted while in CHECK -> outputs 0 immediately; with ITEMGEN_HEAD_EXCL_EN, head=(12,32), 500 runs -> item never (12,32).

Source files
------------

// File: rtl/item_pos_gen.sv
// Food cell generator for the snake game: LFSR draws candidates, rejects walls and body cells.
// Optional build macro ITEMGEN_HEAD_EXCL_EN additionally rejects the new head cell.
module item_pos_gen #(
   parameter int          XSIZE    = 48,
   parameter int          YSIZE    = 64,
   parameter int          MAX_SIZE = 20,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst,
   input  logic                    i_Start,
   input  logic [MAX_SIZE*6-1:0]   i_Body_x,
   input  logic [MAX_SIZE*6-1:0]   i_Body_y,
   input  logic [11:0]             i_Size,
   input  logic [5:0]              i_Head_x,
   input  logic [5:0]              i_Head_y,
   output logic [5:0]              o_Item_x,
   output logic [5:0]              o_Item_y,
   output logic                    o_Done,
   output logic                    o_Busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAW  = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] lfsr;
   logic [4:0]  idx, idx_nxt;
   logic [4:0]  n_len, n_len_nxt;
   logic [5:0]  cand_x, cand_x_nxt;
   logic [5:0]  cand_y, cand_y_nxt;
   logic [5:0]  item_x_nxt, item_y_nxt;
   logic        done_nxt, busy_nxt;

   logic [5:0]  cx, cy;
   logic        in_field, head_ok, draw_ok;
   logic [5:0]  slot_x [MAX_SIZE];
   logic [5:0]  slot_y [MAX_SIZE];
   logic        slot_hit;
   logic [4:0]  n_sat;

   // Free-running candidate source, x^16+x^14+x^13+x^11+1
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign cx = lfsr[5:0];
   assign cy = lfsr[11:6];

   assign in_field = (cx >= 6'd1) && (cx <= 6'(XSIZE - 2)) &&
                     (cy >= 6'd1) && (cy <= 6'(YSIZE - 2));

`ifdef ITEMGEN_HEAD_EXCL_EN
   assign head_ok = !((cx == i_Head_x) && (cy == i_Head_y));
`else
   logic unused_head;
   assign unused_head = ^{i_Head_x, i_Head_y};
   assign head_ok     = 1'b1;
`endif

   assign draw_ok = in_field && head_ok;

   assign n_sat = (i_Size >= 12'(MAX_SIZE)) ? 5'(MAX_SIZE) : i_Size[4:0];

   always_comb begin
      for (int k = 0; k < MAX_SIZE; k++) begin
         slot_x[k] = i_Body_x[k*6 +: 6];
         slot_y[k] = i_Body_y[k*6 +: 6];
      end
   end

   // Single shared comparator walks the body one slot per clock
   always_comb begin
      slot_hit = 1'b0;
      if (idx < 5'(MAX_SIZE)) begin
         slot_hit = (slot_x[idx] == cand_x) && (slot_y[idx] == cand_y);
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      n_len_nxt  = n_len;
      cand_x_nxt = cand_x;
      cand_y_nxt = cand_y;
      item_x_nxt = o_Item_x;
      item_y_nxt = o_Item_y;
      done_nxt   = o_Done;
      busy_nxt   = o_Busy;
      case (state)
         S_IDLE: begin
            if (i_Start) begin
               n_len_nxt = n_sat;
               done_nxt  = 1'b0;
               busy_nxt  = 1'b1;
               state_nxt = S_DRAW;
            end
         end
         S_DRAW: begin
            if (draw_ok) begin
               cand_x_nxt = cx;
               cand_y_nxt = cy;
               idx_nxt    = 5'd0;
               state_nxt  = S_CHECK;
            end
         end
         S_CHECK: begin
            if (idx == n_len) begin
               item_x_nxt = cand_x;
               item_y_nxt = cand_y;
               done_nxt   = 1'b1;
               busy_nxt   = 1'b0;
               state_nxt  = S_IDLE;
            end else if (slot_hit) begin
               state_nxt = S_DRAW;
            end else begin
               idx_nxt = idx + 5'd1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state    <= S_IDLE;
         idx      <= 5'd0;
         o_Item_x <= 6'd0;
         o_Item_y <= 6'd0;
         o_Done   <= 1'b0;
         o_Busy   <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         o_Item_x <= item_x_nxt;
         o_Item_y <= item_y_nxt;
         o_Done   <= done_nxt;
         o_Busy   <= busy_nxt;
      end
   end

   // Working registers are always rewritten before use, so they carry no reset
   always_ff @(posedge i_Clk) begin
      n_len  <= n_len_nxt;
      cand_x <= cand_x_nxt;
      cand_y <= cand_y_nxt;
   end

endmodule

// File: tb/tb_item_pos_gen.sv
// Scoreboard bench for item_pos_gen: a cycle-indexed LFSR table drives a search model.
module tb_item_pos_gen;

   localparam int MAX_SIZE = 20;
   localparam int SEQ_LEN  = 100000;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  start = 1'b0;
   logic [MAX_SIZE*6-1:0] body_x = '0;
   logic [MAX_SIZE*6-1:0] body_y = '0;
   logic [11:0]           size = '0;
   logic [5:0]            head_x = '0;
   logic [5:0]            head_y = '0;
   logic [5:0]            item_x, item_y;
   logic                  done, busy;

   item_pos_gen #(.XSIZE(48), .YSIZE(64), .MAX_SIZE(MAX_SIZE), .SEED(16'hACE1)) dut (
      .i_Clk(clk), .i_Rst(rst_n), .i_Start(start),
      .i_Body_x(body_x), .i_Body_y(body_y), .i_Size(size),
      .i_Head_x(head_x), .i_Head_y(head_y),
      .o_Item_x(item_x), .o_Item_y(item_y), .o_Done(done), .o_Busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int t;
      int tc;
      int c0;
      int n;
   } exp_t;

   exp_t     expq[$];
   bit [15:0] seq [SEQ_LEN];
   int       total = 0;
   int       bad = 0;
   int       cyc;
   logic     prev_done;

   // cyc = clock edges since reset release; the LFSR holds seq[cyc] during that cycle
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int n_of_size();
      return (size >= 12'(MAX_SIZE)) ? MAX_SIZE : int'(size);
   endfunction

   function automatic bit on_body(input int x, input int y, input int n);
      for (int k = 0; k < n; k++)
         if (int'(body_x[k*6 +: 6]) == x && int'(body_y[k*6 +: 6]) == y) return 1'b1;
      return 1'b0;
   endfunction

   // Walk the candidate stream: each cycle of DRAW consumes one LFSR value, a body hit at
   // slot k costs k+2 cycles before the next draw, a clean pass finishes N+1 cycles after it.
   function automatic bit model(input int c0, output exp_t e);
      int d, n, cx, cy, hit;
      bit valid, first;
      n = n_of_size();
      d = c0 + 1;
      first = 1'b1;
      e.c0 = c0; e.n = n; e.tc = 0; e.x = 0; e.y = 0; e.t = 0;
      while (d < SEQ_LEN - 64) begin
         cx = int'(seq[d][5:0]);
         cy = int'(seq[d][11:6]);
         valid = (cx >= 1) && (cx <= 46) && (cy >= 1) && (cy <= 62);
`ifdef ITEMGEN_HEAD_EXCL_EN
         if (cx == int'(head_x) && cy == int'(head_y)) valid = 1'b0;
`endif
         if (!valid) begin
            d++;
         end else begin
            if (first) begin
               e.tc = d + 1;
               first = 1'b0;
            end
            hit = -1;
            for (int k = 0; k < n; k++) begin
               if (hit < 0 && int'(body_x[k*6 +: 6]) == cx && int'(body_y[k*6 +: 6]) == cy)
                  hit = k;
            end
            if (hit < 0) begin
               e.x = cx; e.y = cy; e.t = d + 2 + n;
               return 1'b1;
            end
            d = d + 2 + hit;
         end
      end
      return 1'b0;
   endfunction

   // Monitor: every rising o_Done must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && done && !prev_done) begin
         if (expq.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = expq.pop_front();
            check("item_x", int'(item_x), e.x);
            check("item_y", int'(item_y), e.y);
            check("done_cycle", cyc, e.t);
            check("busy_at_done", int'(busy), 0);
            check("min_latency", int'((cyc - e.c0) >= e.n + 2), 1);
            check("item_on_wall", int'(item_x >= 6'd1 && item_x <= 6'd46 &&
                                       item_y >= 6'd1 && item_y <= 6'd62), 1);
            check("item_on_body", int'(on_body(int'(item_x), int'(item_y), e.n)), 0);
`ifdef ITEMGEN_HEAD_EXCL_EN
            check("item_on_head", int'(item_x == head_x && item_y == head_y), 0);
`endif
         end
      end
      prev_done <= rst_n ? done : 1'b0;
   end

   task automatic wait_empty();
      int g = 0;
      while (expq.size() != 0 && g < 5000) begin
         @(negedge clk);
         g++;
      end
      if (expq.size() != 0) begin
         check("done_timeout", expq.size(), 0);
         expq.delete();
      end
   endtask

   task automatic issue(output exp_t e);
      int g = 0;
      @(negedge clk);
      while (busy && g < 500) begin
         @(negedge clk);
         g++;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start = 1'b1;
      if (model(cyc, e)) expq.push_back(e);
      else check("model_budget", 0, 1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_one(input bit extra_starts);
      exp_t e;
      issue(e);
      if (extra_starts) begin
         // ignored while busy, and ignored in the cycle that returns to IDLE
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         while (cyc < e.t - 1) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (6) begin
            check("hold_done", int'(done), 1);
            check("hold_busy", int'(busy), 0);
            check("hold_x", int'(item_x), e.x);
            check("hold_y", int'(item_y), e.y);
            @(negedge clk);
         end
      end
      wait_empty();
   endtask

   task automatic random_body();
      for (int k = 0; k < MAX_SIZE; k++) begin
         body_x[k*6 +: 6] = 6'($urandom_range(0, 63));
         body_y[k*6 +: 6] = 6'($urandom_range(0, 63));
      end
   endtask

   initial begin
      exp_t e;
      seq[0] = 16'hACE1;
      for (int i = 1; i < SEQ_LEN; i++)
         seq[i] = {seq[i-1][14:0], seq[i-1][15] ^ seq[i-1][13] ^ seq[i-1][12] ^ seq[i-1][10]};

      // T1 reset
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_item_x", int'(item_x), 0);
      check("rst_item_y", int'(item_y), 0);
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 0);
      rst_n = 1'b1;

      // T2 empty snake
      size = 12'd0;
      random_body();
      repeat (20) run_one(1'b0);

      // T3 short snake with a fixed body
      size = 12'd3;
      random_body();
      body_x[0 +: 6] = 6'd24; body_y[0 +: 6] = 6'd32;
      body_x[6 +: 6] = 6'd24; body_y[6 +: 6] = 6'd33;
      body_x[12 +: 6] = 6'd24; body_y[12 +: 6] = 6'd34;
      repeat (500) run_one(1'b0);

      // T4 oversize length saturates
      size = 12'd40;
      repeat (100) begin
         random_body();
         run_one(1'b0);
      end

      // T5 extra starts are ignored
      size = 12'd5;
      random_body();
      repeat (3) run_one(1'b1);

      // T6 asynchronous reset while walking the body
      size = 12'd20;
      random_body();
      issue(e);
      while (cyc < e.tc) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_item_x", int'(item_x), 0);
      check("abort_item_y", int'(item_y), 0);
      check("abort_done", int'(done), 0);
      check("abort_busy", int'(busy), 0);
      expq.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      size = 12'd3;
      repeat (10) run_one(1'b0);

`ifdef ITEMGEN_HEAD_EXCL_EN
      head_x = 6'd12;
      head_y = 6'd32;
      repeat (500) run_one(1'b0);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
